// File: rtl/cmos_capture_rgb565.sv
// CMOS camera byte-stream capture: pairs bytes into RGB565 pixels, skips settle frames, flags framing errors.
// Define CAPTURE_TESTPATTERN_EN to replace camera data with a counter-derived test pattern.
module cmos_capture_rgb565 #(
  parameter int H_PIXELS    = 640,
  parameter int V_LINES     = 480,
  parameter int SKIP_FRAMES = 10
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        cmos_vsyn,
  input  logic        cmos_href,
  input  logic [7:0]  cmos_data,
  input  logic        fifo_full,
  input  logic        clr_err,
  output logic [15:0] pix_data,
  output logic        pix_valid,
  output logic        frame_start,
  output logic        line_end,
  output logic        capturing,
  output logic        line_err,
  output logic        frame_err,
  output logic        ovf_err
);

  localparam int SKIP_W = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;
  localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'(SKIP_FRAMES);
  localparam logic [11:0]       PIX_EXP   = 12'(H_PIXELS);
  localparam logic [10:0]       LINE_EXP  = 11'(V_LINES);

  typedef enum logic [1:0] {
    ST_SKIP   = 2'd0,
    ST_ARM    = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic              vsyn_q, vsyn_dly_q, href_q, href_dly_q;
  logic [SKIP_W-1:0] skip_cnt_q, skip_cnt_d;
  logic [11:0]       pix_cnt_q, pix_cnt_d;
  logic [10:0]       line_cnt_q, line_cnt_d;
  logic              phase_q, phase_d;
  logic              frame_pend_q, frame_pend_d;
  logic [15:0]       pix_data_q, pix_data_d;
  logic              slot_q, slot_d;
  logic              frame_start_q, frame_start_d;
  logic              line_end_q, line_end_d;
  logic              line_err_q, line_err_d;
  logic              frame_err_q, frame_err_d;
  logic              ovf_err_q, ovf_err_d;

  logic        vsyn_rise, href_fall, active, pix_en, pair_done, line_fall;
  logic        frame_edge, frame_check;
  logic [15:0] pix_word;

  assign vsyn_rise = vsyn_q & ~vsyn_dly_q;
  assign href_fall = href_dly_q & ~href_q;
  assign active    = (state_q == ST_ACTIVE);
  // href while vsync is high never produces pixels.
  assign pix_en    = active & href_q & ~vsyn_q;
  assign pair_done = pix_en & phase_q;
  assign line_fall = active & href_fall;

`ifdef CAPTURE_TESTPATTERN_EN
  assign pix_word = {line_cnt_q[4:0], pix_cnt_q[5:0], pix_cnt_q[10:6]};
`else
  logic [7:0] data_q, hi_q;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      data_q <= 8'd0;
      hi_q   <= 8'd0;
    end else begin
      data_q <= cmos_data;
      if (pix_en && !phase_q) hi_q <= data_q;
    end
  end

  assign pix_word = {hi_q, data_q};
`endif

  // NOTE: every variable assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    skip_cnt_d  = skip_cnt_q;
    frame_edge  = 1'b0;
    frame_check = 1'b0;
    case (state_q)
      ST_SKIP: begin
        if (skip_cnt_q == SKIP_LAST) state_d = ST_ARM;
        else if (vsyn_rise)          skip_cnt_d = skip_cnt_q + 1'b1;
      end
      ST_ARM: begin
        if (vsyn_rise) begin
          state_d    = ST_ACTIVE;
          frame_edge = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (vsyn_rise) begin
          frame_edge  = 1'b1;
          frame_check = 1'b1;
        end
      end
      default: state_d = ST_SKIP;
    endcase
  end

  always_comb begin
    phase_d       = pix_en ? ~phase_q : 1'b0;
    slot_d        = pair_done;
    pix_data_d    = pair_done ? pix_word : pix_data_q;
    frame_start_d = pair_done & frame_pend_q;
    line_end_d    = line_fall;

    frame_pend_d = frame_pend_q;
    if (frame_edge)     frame_pend_d = 1'b1;
    else if (pair_done) frame_pend_d = 1'b0;

    pix_cnt_d = pix_cnt_q;
    if (frame_edge || line_fall)      pix_cnt_d = 12'd0;
    else if (pair_done && !(&pix_cnt_q)) pix_cnt_d = pix_cnt_q + 12'd1;

    line_cnt_d = line_cnt_q;
    if (frame_edge)                        line_cnt_d = 11'd0;
    else if (line_fall && !(&line_cnt_q))  line_cnt_d = line_cnt_q + 11'd1;

    // A fresh error in the same cycle as clr_err keeps the flag set.
    line_err_d  = (line_fall & ((pix_cnt_q != PIX_EXP) | phase_q)) | (line_err_q & ~clr_err);
    frame_err_d = (frame_check & (line_cnt_q != LINE_EXP))        | (frame_err_q & ~clr_err);
    ovf_err_d   = (slot_q & fifo_full)                             | (ovf_err_q & ~clr_err);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q       <= ST_SKIP;
      vsyn_q        <= 1'b0;
      vsyn_dly_q    <= 1'b0;
      href_q        <= 1'b0;
      href_dly_q    <= 1'b0;
      skip_cnt_q    <= '0;
      pix_cnt_q     <= 12'd0;
      line_cnt_q    <= 11'd0;
      phase_q       <= 1'b0;
      frame_pend_q  <= 1'b0;
      pix_data_q    <= 16'd0;
      slot_q        <= 1'b0;
      frame_start_q <= 1'b0;
      line_end_q    <= 1'b0;
      line_err_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      ovf_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      vsyn_q        <= cmos_vsyn;
      vsyn_dly_q    <= vsyn_q;
      href_q        <= cmos_href;
      href_dly_q    <= href_q;
      skip_cnt_q    <= skip_cnt_d;
      pix_cnt_q     <= pix_cnt_d;
      line_cnt_q    <= line_cnt_d;
      phase_q       <= phase_d;
      frame_pend_q  <= frame_pend_d;
      pix_data_q    <= pix_data_d;
      slot_q        <= slot_d;
      frame_start_q <= frame_start_d;
      line_end_q    <= line_end_d;
      line_err_q    <= line_err_d;
      frame_err_q   <= frame_err_d;
      ovf_err_q     <= ovf_err_d;
    end
  end

  // The write strobe is gated by the FIFO's full flag in the very cycle it would fire.
  assign pix_valid   = slot_q & ~fifo_full;
  assign pix_data    = pix_data_q;
  assign frame_start = frame_start_q;
  assign line_end    = line_end_q;
  assign capturing   = active;
  assign line_err    = line_err_q;
  assign frame_err   = frame_err_q;
  assign ovf_err     = ovf_err_q;

endmodule

// File: tb/tb_cmos_capture_rgb565.sv
// Bench for cmos_capture_rgb565: cycle tables of camera stimulus checked against a pin-level event model.
module tb_cmos_capture_rgb565;

  localparam int H    = 8;
  localparam int V    = 4;
  localparam int SKIP = 2;
  localparam int MAXC = 3000;
  localparam int ASZ  = MAXC + 8;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        cmos_vsyn = 1'b0, cmos_href = 1'b0, fifo_full = 1'b0, clr_err = 1'b0;
  logic [7:0]  cmos_data = 8'd0;
  logic [15:0] pix_data;
  logic        pix_valid, frame_start, line_end, capturing, line_err, frame_err, ovf_err;

  always #5 CLK = ~CLK;

  cmos_capture_rgb565 #(.H_PIXELS(H), .V_LINES(V), .SKIP_FRAMES(SKIP)) dut (
    .CLK(CLK), .RSTn(RSTn), .cmos_vsyn(cmos_vsyn), .cmos_href(cmos_href), .cmos_data(cmos_data),
    .fifo_full(fifo_full), .clr_err(clr_err), .pix_data(pix_data), .pix_valid(pix_valid),
    .frame_start(frame_start), .line_end(line_end), .capturing(capturing),
    .line_err(line_err), .frame_err(frame_err), .ovf_err(ovf_err)
  );

  // Stimulus table, one entry per clock cycle at the pins.
  bit          sv [ASZ];
  bit          sh [ASZ];
  bit          sf [ASZ];
  bit          sc [ASZ];
  logic [7:0]  sd [ASZ];
  int          n_cyc;
  logic [7:0]  fixed_q [$];

  // Expected outputs per cycle.
  bit          e_val [ASZ];
  bit          e_fs  [ASZ];
  bit          e_le  [ASZ];
  bit          e_cap [ASZ];
  bit          e_lerr[ASZ];
  bit          e_ferr[ASZ];
  bit          e_ovf [ASZ];
  logic [15:0] e_pix [ASZ];
  bit          set_l [ASZ];
  bit          set_f [ASZ];
  bit          set_o [ASZ];

  int tests = 0;
  int fails = 0;
  int cnt_valid, cnt_fs, cnt_le;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".pix_data"},    pix_data, 16'h0000);
    check({tag, ".pix_valid"},   16'(pix_valid), 16'h0);
    check({tag, ".frame_start"}, 16'(frame_start), 16'h0);
    check({tag, ".line_end"},    16'(line_end), 16'h0);
    check({tag, ".capturing"},   16'(capturing), 16'h0);
    check({tag, ".line_err"},    16'(line_err), 16'h0);
    check({tag, ".frame_err"},   16'(frame_err), 16'h0);
    check({tag, ".ovf_err"},     16'(ovf_err), 16'h0);
  endtask

  task automatic clear_stim();
    for (int i = 0; i < ASZ; i++) begin
      sv[i] = 0; sh[i] = 0; sf[i] = 0; sc[i] = 0; sd[i] = 8'd0;
    end
    n_cyc = 0;
  endtask

  task automatic put(input bit v, input bit h, input logic [7:0] d);
    if (n_cyc >= MAXC) begin
      $display("FAIL stim_overflow observed=%0d limit=%0d", n_cyc, MAXC);
      $fatal(1, "stimulus table overflow");
    end
    sv[n_cyc] = v; sh[n_cyc] = h; sd[n_cyc] = d;
    n_cyc++;
  endtask

  task automatic idle(input int k);
    repeat (k) put(1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic vpulse();
    repeat ($urandom_range(1, 3)) put(1'b1, 1'b0, 8'($urandom));
    idle(3);
  endtask

  task automatic clr_pulse();
    sc[n_cyc] = 1'b1;
    idle(1);
  endtask

  // One href-high burst of nb bytes; full_mask bit i holds fifo_full high in pixel i's write slot.
  task automatic line(input int nb, input int full_mask, output int fall_idx);
    logic [7:0] d;
    for (int b = 0; b < nb; b++) begin
      d = (fixed_q.size() > 0) ? fixed_q.pop_front() : 8'($urandom);
      put(1'b0, 1'b1, d);
      if ((b % 2 == 1) && full_mask[b / 2]) sf[n_cyc + 1] = 1'b1;
    end
    fall_idx = n_cyc;
    idle($urandom_range(3, 6));
  endtask

  task automatic frame(input int lines, input int nb);
    int fi;
    vpulse();
    for (int l = 0; l < lines; l++) line(nb, 0, fi);
  endtask

  // Reference model working on pin-cycle events: a second byte at cycle n is written at n+2,
  // an href fall at cycle c ends the line at c+2, a vsync rise at c takes effect at c+2.
  task automatic run_model();
    int         rises = 0, pixcnt = 0, linecnt = 0, cap_from = ASZ;
    bit         act = 0, pend = 0, phase = 0, pv = 0, ph = 0;
    bit         l = 0, f = 0, o = 0, clrp;
    logic [7:0] hi = 8'd0;
    for (int i = 0; i < ASZ; i++) begin
      e_val[i] = 0; e_fs[i] = 0; e_le[i] = 0; e_cap[i] = 0; e_pix[i] = 16'd0;
      set_l[i] = 0; set_f[i] = 0; set_o[i] = 0;
    end
    for (int c = 0; c < n_cyc; c++) begin
      if (act && ph && !sh[c]) begin
        e_le[c + 2] = 1;
        if (pixcnt != H || phase) set_l[c + 2] = 1;
        if (linecnt < 2047) linecnt++;
        pixcnt = 0;
      end
      if (sv[c] && !pv) begin
        rises++;
        if (act) begin
          if (linecnt != V) set_f[c + 2] = 1;
        end else if (rises >= SKIP + 1) begin
          act = 1;
          cap_from = c + 2;
        end
        if (act) begin
          linecnt = 0; pixcnt = 0; phase = 0; pend = 1;
        end
      end
      if (act && sh[c] && !sv[c]) begin
        if (!phase) begin
          hi = sd[c];
          phase = 1;
        end else begin
          e_val[c + 2] = !sf[c + 2];
          e_pix[c + 2] = {hi, sd[c]};
          if (sf[c + 2]) set_o[c + 3] = 1;
          if (pend) begin
            e_fs[c + 2] = 1;
            pend = 0;
          end
          if (pixcnt < 4095) pixcnt++;
          phase = 0;
        end
      end else begin
        phase = 0;
      end
      pv = sv[c];
      ph = sh[c];
    end
    for (int t = 0; t < n_cyc; t++) begin
      clrp = (t > 0) ? sc[t - 1] : 1'b0;
      l = set_l[t] | (l & !clrp);
      f = set_f[t] | (f & !clrp);
      o = set_o[t] | (o & !clrp);
      e_lerr[t] = l; e_ferr[t] = f; e_ovf[t] = o;
      e_cap[t] = (t >= cap_from);
    end
  endtask

  task automatic run_dut(input string seg);
    cnt_valid = 0; cnt_fs = 0; cnt_le = 0;
    for (int c = 0; c < n_cyc; c++) begin
      @(posedge CLK);
      #1;
      cmos_vsyn = sv[c]; cmos_href = sh[c]; cmos_data = sd[c];
      fifo_full = sf[c]; clr_err = sc[c];
      @(negedge CLK);
      check($sformatf("%s.pix_valid@%0d", seg, c),   16'(pix_valid),   16'(e_val[c]));
      check($sformatf("%s.frame_start@%0d", seg, c), 16'(frame_start), 16'(e_fs[c]));
      check($sformatf("%s.line_end@%0d", seg, c),    16'(line_end),    16'(e_le[c]));
      check($sformatf("%s.capturing@%0d", seg, c),   16'(capturing),   16'(e_cap[c]));
      check($sformatf("%s.line_err@%0d", seg, c),    16'(line_err),    16'(e_lerr[c]));
      check($sformatf("%s.frame_err@%0d", seg, c),   16'(frame_err),   16'(e_ferr[c]));
      check($sformatf("%s.ovf_err@%0d", seg, c),     16'(ovf_err),     16'(e_ovf[c]));
      if (e_val[c]) check($sformatf("%s.pix_data@%0d", seg, c), pix_data, e_pix[c]);
      cnt_valid += int'(pix_valid);
      cnt_fs    += int'(frame_start);
      cnt_le    += int'(line_end);
    end
  endtask

  initial begin
    int fi;

    // Reset state.
    repeat (3) @(negedge CLK);
    check_zero("reset");
    RSTn = 1'b1;

    // Segment A: two skipped frames, one clean captured frame, then directed error cases.
    clear_stim();
    idle(5);
    repeat (3) frame(4, 16);
    vpulse();
    fixed_q = '{8'h12, 8'h34, 8'h56, 8'h78};
    line(4, 0, fi);
    line(7, 0, fi);
    clr_pulse();
    line(16, 32'b0110, fi);
    line(16, 0, fi);
    frame(3, 16);
    frame(4, 16);
    clr_pulse();
    vpulse();
    line(16, int'($urandom_range(0, 255)), fi);
    line(5, 0, fi);
    sc[fi + 1] = 1'b1;
    line(16, int'($urandom_range(0, 255)), fi);
    line(16, int'($urandom_range(0, 255)), fi);
    vpulse();
    repeat (6) put(1'b0, 1'b1, 8'($urandom));
    run_model();
    run_dut("segA");

    // Reset in the middle of a line: outputs drop while reset is held.
    #2 RSTn = 1'b0;
    #1 check_zero("midline_rst");
    @(negedge CLK);
    check_zero("midline_rst_hold");
    cmos_vsyn = 1'b0; cmos_href = 1'b0; fifo_full = 1'b0; clr_err = 1'b0;
    @(negedge CLK);
    RSTn = 1'b1;

    // Segment B: settle frames are skipped again after reset.
    clear_stim();
    idle(5);
    repeat (3) frame(4, 16);
    idle(10);
    run_model();
    run_dut("segB");
    check("segB.pix_valid_count",   16'(cnt_valid), 16'd32);
    check("segB.frame_start_count", 16'(cnt_fs),    16'd1);
    check("segB.line_end_count",    16'(cnt_le),    16'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
